// File: rtl/ins_fetch_mem.sv
// Clocked instruction memory with request/response fetch port,
// configurable wait states, fault reporting and a program-load port.
module ins_fetch_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           IReq,
  input  logic [ADDR_W-1:0]              IAddr,
  output logic                           IReady,
  output logic                           IValid,
  input  logic                           IAck,
  output logic [DATA_W-1:0]              IDataOut,
  output logic                           IFault,
  input  logic                           LdEn,
  input  logic [$clog2(DEPTH_WORDS)-1:0] LdAddr,
  input  logic [DATA_W-1:0]              LdData
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              flt_q, flt_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ifl_q, ifl_d;

  logic          accept;
  logic          start;
  logic          enter;
  logic [AW-1:0] req_idx;
  logic          req_flt;
  logic [AW-1:0] rd_idx;
  logic          rd_flt;

  assign IReady = (state_q == S_IDLE)
                | ((state_q == S_RESP) & IAck);
  assign accept = IReq & IReady;

  assign req_idx = IAddr[AW+1:2];
  assign req_flt = (|IAddr[1:0])
                 | (|(IAddr >> (AW + 2)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    flt_d   = flt_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    ifl_d   = ifl_q;
    start   = 1'b0;
    enter   = 1'b0;
    rd_idx  = idx_q;
    rd_flt  = flt_q;

    unique case (1'b1)
      (state_q == S_WAIT): begin
        if (cnt_q == 4'd0) begin
          enter   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      (state_q == S_RESP): begin
        if (IAck) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
          start   = accept;
        end
      end
      default: start = accept;
    endcase

    if (start) begin
      idx_d = req_idx;
      flt_d = req_flt;
      if (WAIT_CYCLES == 0) begin
        enter   = 1'b1;
        rd_idx  = req_idx;
        rd_flt  = req_flt;
        state_d = S_RESP;
      end else begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
    end

    // Read happens before this edge's load write lands
    if (enter) begin
      vld_d = 1'b1;
      ifl_d = rd_flt;
      dat_d = rd_flt ? '0 : mem_q[rd_idx];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      flt_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ifl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      flt_q   <= flt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      ifl_q   <= ifl_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (LdEn) mem_q[LdAddr] <= LdData;
  end

  assign IValid   = vld_q;
  assign IDataOut = dat_q;
  assign IFault   = ifl_q;

endmodule

// File: tb/tb_ins_fetch_mem.sv
// Bench for ins_fetch_mem: three instances (WAIT_CYCLES 0, 1, 3)
// share inputs; each scenario observes one of them.
module tb_ins_fetch_mem;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        IReq = 1'b0;
  logic [31:0] IAddr = '0;
  logic        IAck = 1'b0;
  logic        LdEn = 1'b0;
  logic [7:0]  LdAddr = '0;
  logic [31:0] LdData = '0;

  logic        rdy [3];
  logic        vld [3];
  logic        flt [3];
  logic [31:0] dat [3];

  logic [31:0] mm [256];
  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  ins_fetch_mem #(.WAIT_CYCLES(0)) u0 (
    .CLK(CLK), .Reset(Reset), .IReq(IReq), .IAddr(IAddr),
    .IReady(rdy[0]), .IValid(vld[0]), .IAck(IAck),
    .IDataOut(dat[0]), .IFault(flt[0]),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

  ins_fetch_mem #(.WAIT_CYCLES(1)) u1 (
    .CLK(CLK), .Reset(Reset), .IReq(IReq), .IAddr(IAddr),
    .IReady(rdy[1]), .IValid(vld[1]), .IAck(IAck),
    .IDataOut(dat[1]), .IFault(flt[1]),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

  ins_fetch_mem #(.WAIT_CYCLES(3)) u2 (
    .CLK(CLK), .Reset(Reset), .IReq(IReq), .IAddr(IAddr),
    .IReady(rdy[2]), .IValid(vld[2]), .IAck(IAck),
    .IDataOut(dat[2]), .IFault(flt[2]),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

  task automatic drain();
    IReq = 1'b0;
    IAck = 1'b1;
    LdEn = 1'b0;
    repeat (6) @(negedge CLK);
    IAck = 1'b0;
  endtask

  task automatic do_reset();
    IReq = 1'b0;
    IAck = 1'b0;
    LdEn = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      LdEn   = 1'b1;
      LdAddr = 8'(i);
      LdData = $urandom;
      mm[i]  = LdData;
      @(negedge CLK);
    end
    LdEn = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (vld[s] !== 1'b0 || flt[s] !== 1'b0 || dat[s] !== 32'h0 ||
          rdy[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_idle inst%0d: v=%b f=%b d=%h r=%b want 0 0 0 1",
                 s, vld[s], flt[s], dat[s], rdy[s]);
      end
    end
    IReq  = 1'b1;
    IAddr = 32'h4;
    @(negedge CLK);
    IReq = 1'b0;
    n_chk++;
    if (rdy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_ready: got %b want 0", rdy[2]);
    end
    #2 Reset = 1'b0;
    #1;
    n_chk++;
    if (rdy[2] !== 1'b1 || vld[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: r=%b v=%b want 1 0", rdy[2], vld[2]);
    end
    @(negedge CLK);
    Reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (vld[2] !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_discard: IValid rose=%b want 0", seen);
    end
  endtask

  task automatic test_load_fetch();
    drain();
    LdEn = 1'b1; LdAddr = 8'd0; LdData = 32'h2001_0008;
    mm[0] = LdData;
    @(negedge CLK);
    LdAddr = 8'd1; LdData = 32'h2002_0002;
    mm[1] = LdData;
    @(negedge CLK);
    LdEn = 1'b0;
    IReq = 1'b1; IAddr = 32'h0; IAck = 1'b0;
    @(negedge CLK);
    IReq = 1'b0;
    n_chk++;
    if (vld[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL lf_wait: IValid=%b want 0", vld[1]);
    end
    @(negedge CLK);
    n_chk++;
    if (vld[1] !== 1'b1 || dat[1] !== 32'h2001_0008 || flt[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL lf_first: v=%b d=%h f=%b want 1 20010008 0",
               vld[1], dat[1], flt[1]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_chk++;
      if (vld[1] !== 1'b1 || dat[1] !== 32'h2001_0008 || flt[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL lf_hold%0d: v=%b d=%h f=%b want 1 20010008 0",
                 i, vld[1], dat[1], flt[1]);
      end
    end
    IAck = 1'b1; IReq = 1'b1; IAddr = 32'h4;
    #1;
    n_chk++;
    if (rdy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL lf_ready_ack: got %b want 1", rdy[1]);
    end
    @(negedge CLK);
    IReq = 1'b0;
    n_chk++;
    if (vld[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL lf_drop: IValid=%b want 0", vld[1]);
    end
    @(negedge CLK);
    n_chk++;
    if (vld[1] !== 1'b1 || dat[1] !== 32'h2002_0002) begin
      n_fail++;
      $display("FAIL lf_second: v=%b d=%h want 1 20020002", vld[1], dat[1]);
    end
    @(negedge CLK);
    IAck = 1'b0;
  endtask

  task automatic test_back_to_back();
    drain();
    IReq = 1'b1;
    IAck = 1'b1;
    for (int a = 0; a < 3; a++) begin
      IAddr = 32'(a * 4);
      #1;
      n_chk++;
      if (rdy[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got %b want 1", a, rdy[0]);
      end
      @(negedge CLK);
      n_chk++;
      if (vld[0] !== 1'b1 || dat[0] !== mm[a]) begin
        n_fail++;
        $display("FAIL b2b_word%0d: v=%b d=%h want 1 %h",
                 a, vld[0], dat[0], mm[a]);
      end
    end
    IReq = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: IValid=%b want 0", vld[0]);
    end
    IAck = 1'b0;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic        ef [3];
    logic [31:0] ed [3];
    drain();
    addrs[0] = 32'h0000_0006; ef[0] = 1'b1; ed[0] = 32'h0;
    addrs[1] = 32'h0000_0400; ef[1] = 1'b1; ed[1] = 32'h0;
    addrs[2] = 32'h0000_03FC; ef[2] = 1'b0; ed[2] = mm[255];
    for (int i = 0; i < 3; i++) begin
      IReq = 1'b1; IAck = 1'b0; IAddr = addrs[i];
      @(negedge CLK);
      IReq = 1'b0;
      n_chk++;
      if (vld[0] !== 1'b1 || flt[0] !== ef[i] || dat[0] !== ed[i]) begin
        n_fail++;
        $display("FAIL fault_%h: v=%b f=%b d=%h want 1 %b %h",
                 addrs[i], vld[0], flt[0], dat[0], ef[i], ed[i]);
      end
      IAck = 1'b1;
      @(negedge CLK);
      IAck = 1'b0;
    end
  endtask

  task automatic test_collision();
    drain();
    LdEn = 1'b1; LdAddr = 8'd2; LdData = 32'h0000_1111;
    mm[2] = LdData;
    @(negedge CLK);
    LdEn = 1'b0;
    IReq = 1'b1; IAddr = 32'h8; IAck = 1'b0;
    @(negedge CLK);
    IReq = 1'b0;
    LdEn = 1'b1; LdAddr = 8'd2; LdData = 32'hDEAD_BEEF;
    @(negedge CLK);
    LdEn = 1'b0;
    n_chk++;
    if (vld[1] !== 1'b1 || dat[1] !== 32'h0000_1111) begin
      n_fail++;
      $display("FAIL coll_old: v=%b d=%h want 1 00001111", vld[1], dat[1]);
    end
    mm[2] = 32'hDEAD_BEEF;
    IAck = 1'b1;
    @(negedge CLK);
    IAck = 1'b0;
    IReq = 1'b1; IAddr = 32'h8;
    @(negedge CLK);
    IReq = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (vld[1] !== 1'b1 || dat[1] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL coll_new: v=%b d=%h want 1 deadbeef", vld[1], dat[1]);
    end
    IAck = 1'b1;
    @(negedge CLK);
    IAck = 1'b0;
  endtask

  task automatic test_busy();
    int cnt;
    int at;
    logic [31:0] d;
    drain();
    IAck = 1'b1; IReq = 1'b1; IAddr = 32'h4;
    @(negedge CLK);
    IReq = 1'b0;
    IAddr = 32'h8;
    IReq = 1'b1;
    #1;
    n_chk++;
    if (rdy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: got %b want 0", rdy[2]);
    end
    cnt = 0; at = 0; d = '0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge CLK);
      if (j == 1) IReq = 1'b0;
      if (vld[2] === 1'b1) begin
        cnt++;
        at = j;
        d = dat[2];
      end
    end
    n_chk++;
    if (cnt != 1 || at != 3 || d !== mm[1]) begin
      n_fail++;
      $display("FAIL busy_single: n=%0d at=%0d d=%h want 1 3 %h",
               cnt, at, d, mm[1]);
    end
    IAck = 1'b0;
  endtask

  task automatic test_random(input int sel, input int w, input int n);
    bit pend, resp, eflt, pflt, erdy, acc;
    logic [31:0] edat, a;
    int due, pidx, r;
    do_reset();
    pend = 0; resp = 0; eflt = 0; edat = '0;
    pflt = 0; pidx = 0; due = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      n_chk++;
      if (vld[sel] !== resp || dat[sel] !== edat || flt[sel] !== eflt) begin
        n_fail++;
        $display("FAIL rand_w%0d_c%0d: v=%b d=%h f=%b want %b %h %b",
                 w, k, vld[sel], dat[sel], flt[sel], resp, edat, eflt);
      end
      r = $urandom_range(0, 3);
      if (r <= 1) a = {22'd0, 8'($urandom), 2'b00};
      else if (r == 2) a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else begin
        a = $urandom;
        a[10 + $urandom_range(0, 21)] = 1'b1;
      end
      IAddr  = a;
      IReq   = ($urandom_range(0, 2) != 0);
      IAck   = 1'($urandom_range(0, 1));
      LdEn   = ($urandom_range(0, 3) == 0);
      LdAddr = 8'($urandom);
      LdData = $urandom;
      #1;
      erdy = !pend && (!resp || IAck);
      n_chk++;
      if (rdy[sel] !== erdy) begin
        n_fail++;
        $display("FAIL rand_ready_w%0d_c%0d: got %b want %b",
                 w, k, rdy[sel], erdy);
      end
      acc = IReq && erdy;
      if (resp && IAck) resp = 0;
      if (pend && due == k) begin
        pend = 0;
        resp = 1;
        eflt = pflt;
        edat = pflt ? 32'h0 : mm[pidx];
      end
      if (acc) begin
        pidx = int'(IAddr[9:2]);
        pflt = (IAddr[1:0] != 2'b00) || (IAddr[31:10] != 22'd0);
        if (w == 0) begin
          resp = 1;
          eflt = pflt;
          edat = pflt ? 32'h0 : mm[pidx];
        end else begin
          pend = 1;
          due  = k + w;
        end
      end
      if (LdEn) mm[LdAddr] = LdData;
    end
    @(negedge CLK);
    drain();
  endtask

  initial begin
    test_reset();
    preload();
    test_load_fetch();
    test_back_to_back();
    test_faults();
    test_collision();
    test_busy();
    test_random(0, 0, 300);
    test_random(1, 1, 300);
    test_random(2, 3, 300);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
